// File: rtl/gmii_rx_pkg.sv
// ==== gmii_rx_pkg: shared codes, header offsets and FSM encoding for the GMII UDP receiver (rev 1.0) ====
`default_nettype none

package gmii_rx_pkg;

  localparam logic [7:0]  INFO_VIDEO     = 8'h00;
  localparam logic [7:0]  INFO_AUDIO     = 8'h01;
  localparam logic [7:0]  INFO_VIDAX     = 8'h02;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  // Byte offsets count from the first preamble byte
  localparam logic [10:0] OFF_ETYPE      = 11'd20;
  localparam logic [10:0] OFF_VERIHL     = 11'd22;
  localparam logic [10:0] OFF_PROTO      = 11'd31;
  localparam logic [10:0] OFF_DSTIP      = 11'd38;
  localparam logic [10:0] OFF_DSTPORT    = 11'd44;
  localparam logic [10:0] OFF_INFO       = 11'd50;
  localparam logic [10:0] OFF_LINE       = 11'd51;
  localparam logic [10:0] CNT_MAX        = 11'd2047;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR  = 4'd1,
    ST_INFO = 4'd2,
    ST_LINE = 4'd3,
    ST_VID  = 4'd4,
    ST_AUXH = 4'd5,
    ST_AUX  = 4'd6,
    ST_DONE = 4'd7,
    ST_DROP = 4'd8
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/gmii_byte_packer.sv
// ==== gmii_byte_packer: assembles N bytes MSB-first into a word with a one-cycle done strobe (rev 1.0) ====
`default_nettype none

module gmii_byte_packer #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid,
  input  logic [7:0]     din,
  input  logic           flush,
  input  logic           full,
  output logic [8*N-1:0] data,
  output logic           done,
  output logic           lost
);

  logic [2:0]     r_cnt;
  logic [8*N-1:0] w_word;
  logic           w_last;

  assign w_last = valid && (r_cnt == 3'(N - 1));
  assign lost   = w_last && full;

  generate
    if (N == 1) begin : g_single
      assign w_word = din;
    end else begin : g_multi
      logic [8*(N-1)-1:0] r_hold;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_hold <= '0;
        else if (valid) r_hold <= w_word[8*(N-1)-1:0];
      end
      assign w_word = {r_hold, din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      done <= w_last && !full;
      if (w_last && !full) data <= w_word;
      if (flush || w_last) r_cnt <= '0;
      else if (valid)      r_cnt <= r_cnt + 3'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gmii_udp_rx_demux.sv
// ==== gmii_udp_rx_demux: GMII Ethernet/IPv4/UDP receiver demuxing payload into video/aux FIFOs (rev 1.0) ====
// ==== Optional macro GMII_RX_STATS_EN adds stat_ok/stat_drop/stat_abort counters.
`default_nettype none

module gmii_udp_rx_demux
  import gmii_rx_pkg::*;
#(
  parameter logic [31:0] IPV4_DST  = 32'hC0A80001,
  parameter logic [15:0] DST_PORT  = 16'd12345,
  parameter int          NUM_CH    = 2,
  parameter int          PIX_BYTES = 2,
  parameter int          VID_BYTES = 1200,
  parameter int          AUX_BYTES = 3,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk125,
  input  logic                            sys_rst_n,
  input  logic [7:0]                      rxd,
  input  logic                            rx_dv,
  input  logic                            vid_full,
  input  logic                            aux_full,
  output logic [CH_W+16+8*PIX_BYTES-1:0]  vid_data,
  output logic                            vid_wr_en,
  output logic [CH_W+8*AUX_BYTES-1:0]     aux_data,
  output logic                            aux_wr_en,
  output logic                            packet_en,
  output logic                            pkt_abort
`ifdef GMII_RX_STATS_EN
  ,
  output logic [15:0]                     stat_ok,
  output logic [15:0]                     stat_drop,
  output logic [15:0]                     stat_abort
`endif
);

  rx_state_t r_state, w_next;

  logic [10:0]            r_cnt;
  logic [15:0]            r_etype, r_dst_port, r_rem, w_port_off;
  logic [7:0]             r_verihl, r_proto;
  logic [31:0]            r_dst_ip;
  logic [CH_W-1:0]        r_ch;
  logic [3:0]             r_x;
  logic [11:0]            r_y;
  logic                   r_has_aux, r_abort;
  logic                   w_hdr_ok, w_info_ok, w_abort, w_flush;
  logic                   w_vid_valid, w_aux_valid, w_vid_lost, w_aux_lost;
  logic                   w_vid_done, w_aux_done;
  logic [8*PIX_BYTES-1:0] w_vid_word;
  logic [8*AUX_BYTES-1:0] w_aux_word;

  // Offset compare keeps the port range check free of 16-bit wrap
  assign w_port_off = r_dst_port - DST_PORT;
  assign w_hdr_ok   = (r_etype == ETHERTYPE_IPV4) && (r_verihl == IP_VER_IHL) &&
                      (r_proto == IP_PROTO_UDP) && (r_dst_ip == IPV4_DST) &&
                      (r_dst_port >= DST_PORT) && (w_port_off < 16'(NUM_CH));
  assign w_info_ok  = (rxd == INFO_VIDEO) || (rxd == INFO_AUDIO) || (rxd == INFO_VIDAX);

  assign w_vid_valid = rx_dv && (r_state == ST_VID);
  assign w_aux_valid = rx_dv && (r_state == ST_AUX);
  assign packet_en   = r_state inside {ST_LINE, ST_VID, ST_AUXH, ST_AUX};
  assign w_abort     = (!rx_dv && packet_en) || w_vid_lost || w_aux_lost;
  assign w_flush     = w_abort || (r_state == ST_INFO);
  assign pkt_abort   = r_abort;

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!rx_dv) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_HDR;
        ST_HDR:  if (r_cnt == OFF_INFO - 11'd1) w_next = ST_INFO;
        ST_INFO: begin
          if (!(w_hdr_ok && w_info_ok)) w_next = ST_DROP;
          else if (rxd == INFO_AUDIO)   w_next = ST_AUXH;
          else                          w_next = ST_LINE;
        end
        ST_LINE: if (r_cnt == OFF_LINE + 11'd1) w_next = ST_VID;
        ST_VID: begin
          if (w_vid_lost)          w_next = ST_DROP;
          else if (r_rem == 16'd1) w_next = r_has_aux ? ST_AUXH : ST_DONE;
        end
        ST_AUXH: w_next = (rxd[3:0] == 4'd0) ? ST_DONE : ST_AUX;
        ST_AUX: begin
          if (w_aux_lost)          w_next = ST_DROP;
          else if (r_rem == 16'd1) w_next = ST_DONE;
        end
        ST_DONE, ST_DROP: w_next = r_state;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt      <= '0;
      r_etype    <= '0;
      r_verihl   <= '0;
      r_proto    <= '0;
      r_dst_ip   <= '0;
      r_dst_port <= '0;
      r_ch       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_has_aux  <= 1'b0;
      r_rem      <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (!rx_dv)                r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 11'd1;

      if (rx_dv) begin
        if (r_cnt == OFF_ETYPE || r_cnt == OFF_ETYPE + 11'd1) r_etype <= {r_etype[7:0], rxd};
        if (r_cnt == OFF_VERIHL) r_verihl <= rxd;
        if (r_cnt == OFF_PROTO)  r_proto  <= rxd;
        if (r_cnt >= OFF_DSTIP && r_cnt <= OFF_DSTIP + 11'd3) r_dst_ip <= {r_dst_ip[23:0], rxd};
        if (r_cnt == OFF_DSTPORT || r_cnt == OFF_DSTPORT + 11'd1)
          r_dst_port <= {r_dst_port[7:0], rxd};

        case (r_state)
          ST_INFO: begin
            if (w_next != ST_DROP) begin
              r_ch      <= w_port_off[CH_W-1:0];
              r_has_aux <= (rxd == INFO_VIDAX);
            end
          end
          ST_LINE: begin
            if (r_cnt == OFF_LINE) begin
              r_y[7:0] <= rxd;
            end else begin
              r_x       <= rxd[7:4];
              r_y[11:8] <= rxd[3:0];
              r_rem     <= 16'(VID_BYTES);
            end
          end
          ST_VID, ST_AUX: r_rem <= r_rem - 16'd1;
          ST_AUXH:        r_rem <= 16'(rxd[3:0] * AUX_BYTES);
          default:        r_rem <= r_rem;
        endcase
      end
    end
  end

  gmii_byte_packer #(.N(PIX_BYTES)) u_vid_packer (
    .clk   (clk125),
    .rst_n (sys_rst_n),
    .valid (w_vid_valid),
    .din   (rxd),
    .flush (w_flush),
    .full  (vid_full),
    .data  (w_vid_word),
    .done  (w_vid_done),
    .lost  (w_vid_lost)
  );

  gmii_byte_packer #(.N(AUX_BYTES)) u_aux_packer (
    .clk   (clk125),
    .rst_n (sys_rst_n),
    .valid (w_aux_valid),
    .din   (rxd),
    .flush (w_flush),
    .full  (aux_full),
    .data  (w_aux_word),
    .done  (w_aux_done),
    .lost  (w_aux_lost)
  );

  assign vid_data  = {r_ch, r_x, r_y, w_vid_word};
  assign vid_wr_en = w_vid_done;
  assign aux_data  = {r_ch, w_aux_word};
  assign aux_wr_en = w_aux_done;

`ifdef GMII_RX_STATS_EN
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_ok    <= '0;
      stat_drop  <= '0;
      stat_abort <= '0;
    end else begin
      if (w_next == ST_DONE && r_state != ST_DONE) stat_ok   <= stat_ok + 16'd1;
      if (w_next == ST_DROP && r_state != ST_DROP) stat_drop <= stat_drop + 16'd1;
      if (w_abort) stat_abort <= stat_abort + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gmii_udp_rx_demux.sv
// ==== tb_gmii_udp_rx_demux: directed self-checking bench for gmii_udp_rx_demux (rev 1.0) ====
`timescale 1ns/1ps
`default_nettype none

module tb_gmii_udp_rx_demux;

  logic        clk125    = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_dv     = 1'b0;
  logic        vid_full  = 1'b0;
  logic        aux_full  = 1'b0;
  logic [7:0]  rxd       = 8'h00;
  logic [32:0] vid_data;
  logic [24:0] aux_data;
  logic        vid_wr_en, aux_wr_en, packet_en, pkt_abort;
`ifdef GMII_RX_STATS_EN
  logic [15:0] stat_ok, stat_drop, stat_abort;
`endif

  always #4 clk125 = ~clk125;

  gmii_udp_rx_demux dut (
    .clk125    (clk125),
    .sys_rst_n (sys_rst_n),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .vid_full  (vid_full),
    .aux_full  (aux_full),
    .vid_data  (vid_data),
    .vid_wr_en (vid_wr_en),
    .aux_data  (aux_data),
    .aux_wr_en (aux_wr_en),
    .packet_en (packet_en),
    .pkt_abort (pkt_abort)
`ifdef GMII_RX_STATS_EN
    ,
    .stat_ok    (stat_ok),
    .stat_drop  (stat_drop),
    .stat_abort (stat_abort)
`endif
  );

  int tests = 0, fails = 0;
  int vid_cnt = 0, aux_cnt = 0, abort_cnt = 0, pen_cnt = 0, bad_cnt = 0;
  int vid_idx = 0, aux_idx = 0;
  int v0, a0, ab0, p0, b0;
  logic [32:0] last_vid = '0;
  logic [24:0] last_aux = '0;
  logic [0:0]  exp_ch = 1'b0;
  logic [3:0]  exp_x  = 4'h5;
  logic [11:0] exp_y  = 12'h123;
  logic [7:0]  frm[$];

  // Observer: video byte k carries k[7:0], aux byte k carries A0+k
  always @(negedge clk125) begin
    if (packet_en) pen_cnt++;
    if (pkt_abort) abort_cnt++;
    if (vid_wr_en) begin
      vid_cnt++;
      last_vid = vid_data;
      if (vid_data !== {exp_ch, exp_x, exp_y, 8'(2*vid_idx), 8'(2*vid_idx+1)}) bad_cnt++;
      vid_idx++;
    end else if (!packet_en) vid_idx = 0;
    if (aux_wr_en) begin
      aux_cnt++;
      last_aux = aux_data;
      if (aux_data !== {exp_ch, 8'(8'hA0 + 3*aux_idx), 8'(8'hA1 + 3*aux_idx), 8'(8'hA2 + 3*aux_idx)})
        bad_cnt++;
      aux_idx++;
    end else if (!packet_en) aux_idx = 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    v0 = vid_cnt; a0 = aux_cnt; ab0 = abort_cnt; p0 = pen_cnt; b0 = bad_cnt;
  endtask

  task automatic send(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] info,
                      input int nvid, input int naux, input int cut, input int full_at,
                      input bit hold, input int gap);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(8'h02);
    for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45); frm.push_back(8'h00);
    repeat (6) frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h0A);
    frm.push_back(ip[31:24]); frm.push_back(ip[23:16]); frm.push_back(ip[15:8]); frm.push_back(ip[7:0]);
    frm.push_back(8'h12); frm.push_back(8'h34);
    frm.push_back(port[15:8]); frm.push_back(port[7:0]);
    repeat (4) frm.push_back(8'h00);
    frm.push_back(info);
    if (info != 8'h01) begin
      frm.push_back(exp_y[7:0]);
      frm.push_back({exp_x, exp_y[11:8]});
      for (int i = 0; i < nvid; i++) frm.push_back(8'(i));
    end
    if (info == 8'h01 || info == 8'h02) begin
      frm.push_back(8'(naux));
      for (int i = 0; i < naux*3; i++) frm.push_back(8'hA0 + 8'(i));
    end
    repeat (4) frm.push_back(8'hEE);
    for (int i = 0; i < frm.size() && (cut < 0 || i < cut); i++) begin
      @(posedge clk125); #1;
      rx_dv = 1'b1;
      rxd   = frm[i];
      if (full_at >= 0 && i >= full_at) vid_full = 1'b1;
    end
    if (!hold) begin
      @(posedge clk125); #1;
      rx_dv = 1'b0; rxd = 8'h00; vid_full = 1'b0;
      repeat (gap) @(posedge clk125);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk125);
    #1;
    check("rst_vid_wr_en", 64'(vid_wr_en), 64'd0);
    check("rst_aux_wr_en", 64'(aux_wr_en), 64'd0);
    check("rst_packet_en", 64'(packet_en), 64'd0);
    check("rst_pkt_abort", 64'(pkt_abort), 64'd0);
    check("rst_vid_data",  64'(vid_data),  64'd0);
    check("rst_aux_data",  64'(aux_data),  64'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge clk125);

    // Video frame, channel 0
    exp_ch = 1'b0; exp_x = 4'h5; exp_y = 12'h123;
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("f1_vid_words", 64'(vid_cnt - v0), 64'd600);
    check("f1_word_data", 64'(bad_cnt - b0), 64'd0);
    check("f1_aux_words", 64'(aux_cnt - a0), 64'd0);
    check("f1_abort",     64'(abort_cnt - ab0), 64'd0);
    check("f1_last_word", 64'(last_vid), 64'({1'b0, 4'h5, 12'h123, 8'hAE, 8'hAF}));
    check("f1_packet_en", 64'((pen_cnt - p0) >= 1200), 64'd1);

    // Video + aux frame, channel 1
    exp_ch = 1'b1;
    snap();
    send(32'hC0A80001, 16'd12346, 8'h02, 1200, 3, -1, -1, 1'b0, 4);
    check("f2_vid_words", 64'(vid_cnt - v0), 64'd600);
    check("f2_aux_recs",  64'(aux_cnt - a0), 64'd3);
    check("f2_data",      64'(bad_cnt - b0), 64'd0);
    check("f2_vid_ch",    64'(last_vid[32]), 64'd1);
    check("f2_last_aux",  64'(last_aux), 64'({1'b1, 8'hA6, 8'hA7, 8'hA8}));

    // Filtered frames: wrong IP, port just past range, port just below range, bad info byte
    exp_ch = 1'b0;
    snap();
    send(32'hC0A80002, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("bad_ip_writes", 64'((vid_cnt - v0) + (aux_cnt - a0)), 64'd0);
    check("bad_ip_pen",    64'(pen_cnt - p0), 64'd0);
    snap();
    send(32'hC0A80001, 16'd12347, 8'h02, 1200, 2, -1, -1, 1'b0, 4);
    check("port_hi_writes", 64'((vid_cnt - v0) + (aux_cnt - a0)), 64'd0);
    check("port_hi_pen",    64'(pen_cnt - p0), 64'd0);
    snap();
    send(32'hC0A80001, 16'd12344, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("port_lo_writes", 64'((vid_cnt - v0) + (aux_cnt - a0)), 64'd0);
    check("port_lo_pen",    64'(pen_cnt - p0), 64'd0);
    snap();
    send(32'hC0A80001, 16'd12345, 8'h03, 1200, 0, -1, -1, 1'b0, 4);
    check("bad_info_writes", 64'((vid_cnt - v0) + (aux_cnt - a0)), 64'd0);
    check("bad_info_pen",    64'(pen_cnt - p0), 64'd0);

    // Aux-only frame with two records
    snap();
    send(32'hC0A80001, 16'd12345, 8'h01, 0, 2, -1, -1, 1'b0, 4);
    check("aud_aux_recs",  64'(aux_cnt - a0), 64'd2);
    check("aud_vid_words", 64'(vid_cnt - v0), 64'd0);
    check("aud_last_aux",  64'(last_aux), 64'({1'b0, 8'hA3, 8'hA4, 8'hA5}));
    check("aud_data",      64'(bad_cnt - b0), 64'd0);

    // rx_dv drops after 101 video bytes
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, 53 + 101, -1, 1'b0, 4);
    check("cut_vid_words", 64'(vid_cnt - v0), 64'd50);
    check("cut_abort",     64'(abort_cnt - ab0), 64'd1);
    check("cut_data",      64'(bad_cnt - b0), 64'd0);

    // vid_full asserted as word 10 completes
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, 53 + 19, 1'b0, 4);
    check("full_vid_words", 64'(vid_cnt - v0), 64'd9);
    check("full_abort",     64'(abort_cnt - ab0), 64'd1);
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("after_full_words", 64'(vid_cnt - v0), 64'd600);
    check("after_full_abort", 64'(abort_cnt - ab0), 64'd0);

    // Reset in the middle of the video payload
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, 53 + 40, -1, 1'b1, 0);
    @(posedge clk125); #1;
    check("mid_word_before_rst", 64'({vid_wr_en, packet_en, vid_data}),
          64'({1'b1, 1'b1, 1'b0, 4'h5, 12'h123, 8'h26, 8'h27}));
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 64'({vid_wr_en, aux_wr_en, packet_en, pkt_abort, vid_data, aux_data}), 64'd0);
    rx_dv = 1'b0; rxd = 8'h00;
    repeat (3) @(posedge clk125);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(posedge clk125);
    check("mid_rst_abort", 64'(abort_cnt - ab0), 64'd0);
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("after_rst_words", 64'(vid_cnt - v0), 64'd600);
    check("after_rst_data",  64'(bad_cnt - b0), 64'd0);

    // Back-to-back frames separated by one idle cycle
    snap();
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 1);
    send(32'hC0A80001, 16'd12345, 8'h00, 1200, 0, -1, -1, 1'b0, 4);
    check("b2b_vid_words", 64'(vid_cnt - v0), 64'd1200);
    check("b2b_data",      64'(bad_cnt - b0), 64'd0);
    check("b2b_abort",     64'(abort_cnt - ab0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
